// File: rtl/reg_file_sb.sv
// Parametrised register file: two combinational read ports, one write port,
// write->read bypass, and a per-register busy scoreboard. Optional macro RF_ZERO_REG_EN hardwires register 0 to zero.
module reg_file_sb #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              wen,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_rd,
    output logic              rsv_ok,
    output logic [ADDR_W:0]   busy_cnt
);

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0]   regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [ADDR_W:0]     busy_cnt_reg;
    logic [ADDR_W:0]     busy_cnt_next;

    // One-hot decodes; out-of-range addresses simply match no register.
    logic [NUM_REGS-1:0] wr_dec;
    logic [NUM_REGS-1:0] rs1_dec;
    logic [NUM_REGS-1:0] rs2_dec;
    logic [NUM_REGS-1:0] rsv_dec;
    logic [NUM_REGS-1:0] rsv_grant;
    logic [NUM_REGS-1:0] rsv_set;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam bit IS_ZERO = ZERO_REG && (gi == 0);

            assign wr_dec[gi]    = wen && (rd == ADDR_W'(gi)) && !IS_ZERO;
            assign rs1_dec[gi]   = (rs1 == ADDR_W'(gi));
            assign rs2_dec[gi]   = (rs2 == ADDR_W'(gi));
            assign rsv_dec[gi]   = rsv_en && (rsv_rd == ADDR_W'(gi));
            assign rsv_grant[gi] = rsv_dec[gi] && (!busy_reg[gi] || wr_dec[gi]);
            // A hardwired zero register grants reservations but never tracks them.
            assign rsv_set[gi]   = rsv_grant[gi] && !IS_ZERO;
            // Set wins over clear when write-back and reserve hit the same register.
            assign busy_next[gi] = (busy_reg[gi] && !wr_dec[gi]) || rsv_set[gi];

            always_ff @(posedge clk or negedge areset) begin
                if (!areset) begin
                    regs_reg[gi] <= '0;
                end else if (wr_dec[gi]) begin
                    regs_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    logic [DATA_W-1:0] rs1_mux;
    logic [DATA_W-1:0] rs2_mux;

    always_comb begin
        rs1_mux = '0;
        rs2_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rs1_dec[i]) rs1_mux = regs_reg[i];
            if (rs2_dec[i]) rs2_mux = regs_reg[i];
        end
    end

    assign rs1_data = |(wr_dec & rs1_dec) ? wdata : rs1_mux;
    assign rs2_data = |(wr_dec & rs2_dec) ? wdata : rs2_mux;
    assign rs1_busy = |(rs1_dec & busy_reg & ~wr_dec);
    assign rs2_busy = |(rs2_dec & busy_reg & ~wr_dec);
    assign rsv_ok   = |rsv_grant;

    always_comb begin
        busy_cnt_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_cnt_next = busy_cnt_next + (ADDR_W+1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios then random traffic,
// checked against an array-based model on a 4-register and a 3-register instance.
module tb_reg_file_sb;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic       wen = 1'b0;
    logic [1:0] rd = '0;
    logic [7:0] wdata = '0;
    logic [1:0] rs1 = '0;
    logic [1:0] rs2 = '0;
    logic       rsv_en = 1'b0;
    logic [1:0] rsv_rd = '0;

    logic [7:0] o_rs1_data [2];
    logic [7:0] o_rs2_data [2];
    logic       o_rs1_busy [2];
    logic       o_rs2_busy [2];
    logic       o_rsv_ok   [2];
    logic [2:0] o_busy_cnt [2];

    int checks = 0;
    int failures = 0;
    int txn = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.NUM_REGS(4), .DATA_W(8)) u_dut4 (
        .clk(clk), .areset(areset), .wen(wen), .rd(rd), .wdata(wdata),
        .rs1(rs1), .rs2(rs2), .rs1_data(o_rs1_data[0]), .rs2_data(o_rs2_data[0]),
        .rs1_busy(o_rs1_busy[0]), .rs2_busy(o_rs2_busy[0]),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .rsv_ok(o_rsv_ok[0]), .busy_cnt(o_busy_cnt[0])
    );

    reg_file_sb #(.NUM_REGS(3), .DATA_W(8)) u_dut3 (
        .clk(clk), .areset(areset), .wen(wen), .rd(rd), .wdata(wdata),
        .rs1(rs1), .rs2(rs2), .rs1_data(o_rs1_data[1]), .rs2_data(o_rs2_data[1]),
        .rs1_busy(o_rs1_busy[1]), .rs2_busy(o_rs2_busy[1]),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .rsv_ok(o_rsv_ok[1]), .busy_cnt(o_busy_cnt[1])
    );

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    // Reference model: index 0 -> 4-register instance, index 1 -> 3-register instance.
    int         nr [2] = '{4, 3};
    logic [7:0] mregs [2][4];
    bit         mbusy [2][4];

    function automatic bit m_valid(int k, logic [1:0] a);
        return int'(a) < nr[k];
    endfunction

    function automatic bit m_wr_hits(int k, logic [1:0] a);
        return wen && rd == a && m_valid(k, rd) && !(ZERO_REG && rd == 2'd0);
    endfunction

    function automatic logic [7:0] m_read(int k, logic [1:0] a);
        if (!m_valid(k, a)) return 8'h00;
        if (m_wr_hits(k, a)) return wdata;
        return mregs[k][a];
    endfunction

    function automatic bit m_busy(int k, logic [1:0] a);
        if (!m_valid(k, a)) return 1'b0;
        if (m_wr_hits(k, a)) return 1'b0;
        return mbusy[k][a];
    endfunction

    function automatic bit m_ok(int k);
        return rsv_en && m_valid(k, rsv_rd) && (!mbusy[k][rsv_rd] || m_wr_hits(k, rsv_rd));
    endfunction

    function automatic int m_count(int k);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(mbusy[k][i]);
        return n;
    endfunction

    task automatic m_commit();
        for (int k = 0; k < 2; k++) begin
            bit ok = m_ok(k);
            if (m_wr_hits(k, rd)) begin
                mregs[k][rd] = wdata;
                mbusy[k][rd] = 1'b0;
            end
            if (ok && !(ZERO_REG && rsv_rd == 2'd0)) mbusy[k][rsv_rd] = 1'b1;
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                mregs[k][i] = 8'h00;
                mbusy[k][i] = 1'b0;
            end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string phase);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_n%0d_rs1_data", phase, nr[k]), 32'(o_rs1_data[k]), 32'(m_read(k, rs1)));
            chk($sformatf("%s_n%0d_rs2_data", phase, nr[k]), 32'(o_rs2_data[k]), 32'(m_read(k, rs2)));
            chk($sformatf("%s_n%0d_rs1_busy", phase, nr[k]), 32'(o_rs1_busy[k]), 32'(m_busy(k, rs1)));
            chk($sformatf("%s_n%0d_rs2_busy", phase, nr[k]), 32'(o_rs2_busy[k]), 32'(m_busy(k, rs2)));
            chk($sformatf("%s_n%0d_rsv_ok", phase, nr[k]), 32'(o_rsv_ok[k]), 32'(m_ok(k)));
            chk($sformatf("%s_n%0d_busy_cnt", phase, nr[k]), 32'(o_busy_cnt[k]), 32'(m_count(k)));
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] r, input logic [7:0] d,
                         input logic [1:0] s1, input logic [1:0] s2,
                         input logic re, input logic [1:0] rr);
        wen = w; rd = r; wdata = d; rs1 = s1; rs2 = s2; rsv_en = re; rsv_rd = rr;
    endtask

    // Inputs are applied at the falling edge; outputs are checked 1ns later,
    // then again 1ns after the rising edge, and the task returns at the next falling edge.
    task automatic cycle();
        #1;
        check_all("pre");
        $display("txn %0d wen=%0b rd=%0d wdata=%02h rs1=%0d rs2=%0d rsv_en=%0b rsv_rd=%0d rsv_ok=%0b cnt=%0d",
                 txn, wen, rd, wdata, rs1, rs2, rsv_en, rsv_rd, o_rsv_ok[0], o_busy_cnt[0]);
        txn++;
        @(posedge clk);
        m_commit();
        #1;
        check_all("post");
        @(negedge clk);
    endtask

    initial begin
        m_clear();
        drive(0, 0, 8'h00, 2, 3, 0, 0);
        #100;
        check_all("reset");
        chk("reset_rs1_data", 32'(o_rs1_data[0]), 32'h00);
        chk("reset_busy_cnt", 32'(o_busy_cnt[0]), 32'd0);
        @(negedge clk);
        areset = 1'b1;

        // Write / read back
        drive(1, 2, 8'h55, 2, 3, 0, 0); cycle();
        drive(1, 3, 8'h1E, 2, 3, 0, 0); cycle();
        drive(0, 0, 8'h00, 2, 3, 0, 0); cycle();
        chk("wr_rs1_data", 32'(o_rs1_data[0]), 32'h55);
        chk("wr_rs2_data", 32'(o_rs2_data[0]), 32'h1E);

        // Bypass
        drive(1, 1, 8'hA7, 1, 0, 0, 0);
        #1 chk("bypass_same_cycle", 32'(o_rs1_data[0]), 32'hA7);
        cycle();
        drive(0, 0, 8'h00, 1, 0, 0, 0); cycle();
        chk("bypass_after", 32'(o_rs1_data[0]), 32'hA7);

        // Scoreboard
        drive(0, 0, 8'h00, 0, 3, 1, 3);
        #1 chk("sb_rsv_ok", 32'(o_rsv_ok[0]), 32'd1);
        cycle();
        drive(0, 0, 8'h00, 0, 3, 1, 3);
        #1 chk("sb_rsv_again", 32'(o_rsv_ok[0]), 32'd0);
        chk("sb_rs2_busy", 32'(o_rs2_busy[0]), 32'd1);
        cycle();
        chk("sb_cnt_held", 32'(o_busy_cnt[0]), 32'd1);
        drive(1, 3, 8'h3C, 0, 3, 0, 0);
        #1 chk("sb_wb_busy_clear", 32'(o_rs2_busy[0]), 32'd0);
        cycle();
        chk("sb_cnt_zero", 32'(o_busy_cnt[0]), 32'd0);
        chk("sb_rs2_data", 32'(o_rs2_data[0]), 32'h3C);

        // Collision: write-back and reserve of the same busy register
        drive(0, 0, 8'h00, 0, 2, 1, 2); cycle();
        drive(1, 2, 8'h11, 0, 2, 1, 2);
        #1 chk("col_rsv_ok", 32'(o_rsv_ok[0]), 32'd1);
        cycle();
        drive(0, 0, 8'h00, 0, 2, 0, 0); cycle();
        chk("col_reg2", 32'(o_rs2_data[0]), 32'h11);
        chk("col_busy2", 32'(o_rs2_busy[0]), 32'd1);
        chk("col_cnt", 32'(o_busy_cnt[0]), 32'd1);

        // Write to register 3 and reserve register 1 in the same cycle
        drive(1, 3, 8'h77, 1, 3, 1, 1); cycle();
        chk("indep_cnt", 32'(o_busy_cnt[0]), 32'd2);

        // Asynchronous reset between edges
        drive(0, 0, 8'h00, 2, 3, 0, 0);
        #2 areset = 1'b0;
        m_clear();
        #1;
        check_all("async_rst");
        chk("async_rst_cnt", 32'(o_busy_cnt[0]), 32'd0);
        chk("async_rst_rs2", 32'(o_rs2_data[0]), 32'h00);
        @(negedge clk);
        areset = 1'b1;
        drive(1, 0, 8'hFF, 0, 1, 1, 0); cycle();

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
                  1'($urandom_range(0, 1)), 2'($urandom));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
